q_sys_spi_slave: RTL
====================

Q_SYS_SPI_SLAVE -- requirements
Module: q_sys_spi_slave

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 The block SHALL have parameter DATABITS, default 8, meaning the frame width in bits (legal range 4..16).
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of flops per SPI input synchronizer (2..3).
REQ-004 clk  in  1  system clock; all state on its rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 SCLK  in  1  SPI clock from the master; mode 0 (CPOL=0, CPHA=0).
REQ-007 SS_n  in  1  slave select, active low.
REQ-008 MOSI  in  1  serial data from the master, MSB first.
REQ-009 MISO  out  1  serial data to the master, MSB first.
REQ-010 mem_addr  in  3  register address: 0 rxdata (r), 1 txdata (w), 2 status (r/w), 3 control (r/w), 6 eop-value (r/w).
REQ-011 data_from_cpu  in  16  write data.
REQ-012 data_to_cpu  out  16  registered read data.
REQ-013 read_n, write_n, spi_select  in  1 each  bus strobes, active low / active high.
REQ-014 irq, dataavailable, readyfordata, endofpacket  out  1 each  interrupt, RRDY, TRDY, EOP.

Function
REQ-015 SCLK, SS_n and MOSI SHALL pass through SYNC_STAGES-flop synchronizers; SCLK edges SHALL be detected from the synced value; clk SHALL be at least 8x SCLK.
REQ-016 Bus access: a read or write SHALL take effect once, on the first clk with spi_select and an active strobe; a repeat SHALL need one idle cycle; data_to_cpu SHALL be valid 1 clk after the read strobe.
REQ-017 Frame start (synced SS_n falling): load tx_shift from tx_holding if TRDY=0 (TRDY SHALL then go to 1), else from 0; clear bit_count.
REQ-018 On a synced SCLK rising edge with SS_n low: sample MOSI into rx_shift LSB; increment bit_count.
REQ-019 On a synced SCLK falling edge with SS_n low: shift tx_shift left; when bit_count==DATABITS, reload tx_shift as in REQ-017 and clear bit_count.
REQ-020 At the sample with bit_count reaching DATABITS: rx_holding <= completed byte; RRDY <= 1; ROE <= 1 if RRDY was already 1 (old rx_holding is overwritten).
REQ-021 MISO SHALL equal tx_shift[DATABITS-1] while SS_n is synced low.
REQ-022 SS_n rising mid-frame SHALL discard the partial frame, clear bit_count, and leave RRDY and ROE unchanged.
REQ-023 A txdata write when TRDY=1 SHALL load tx_holding and set TRDY=0; a write when TRDY=0 SHALL be dropped and set TOE=1.
REQ-024 TMT SHALL equal TRDY & ~frame-active.
REQ-025 An rxdata read SHALL clear RRDY; if it coincides with a new byte completing, RRDY SHALL stay 1, ROE SHALL not be set, and the read SHALL return the old byte.
REQ-026 EOP SHALL be set by an rxdata read whose rx_holding equals eop-value, or by a txdata write whose data equals eop-value.
REQ-027 Status layout: bit9 EOP, bit8 E=TOE|ROE, bit7 RRDY, bit6 TRDY, bit5 TMT, bit4 TOE, bit3 ROE; other bits 0.
REQ-028 A status write SHALL clear EOP, ROE and TOE; a same-cycle set event SHALL win.
REQ-029 Control layout: bits 9,8,7,6,4,3 enable irq for the matching status bit; read back as written.
REQ-030 irq SHALL be registered: the OR of each enabled status bit, 1 clk after the cause.
REQ-031 Unmapped read addresses SHALL return 0; unmapped writes SHALL be ignored.

Reset
REQ-032 Reset SHALL clear all shift registers, holding registers, bit_count, control, eop-value, EOP, RRDY, ROE, TOE and irq, set TRDY=1, and drive data_to_cpu=0.
REQ-033 Synchronizers SHALL reset to idle (SCLK=0, SS_n=1), so a reset released mid-frame does not start a frame until the next SS_n falling edge.

Configuration
REQ-034 With SPI_SLAVE_MISO_TRISTATE_EN defined, MISO SHALL be 1'bz while synced SS_n is high; without it, MISO SHALL drive 0 while SS_n is high.

Verification
REQ-035 Write txdata 0xA5, master sends 0x3C at SCLK=clk/16 -> MISO bits 1,0,1,0,0,1,0,1; RRDY=1; rxdata reads 0x3C; RRDY=0.
REQ-036 Two bytes without reading rxdata -> ROE=1, E=1, rxdata holds the second byte; status write -> ROE=0, E=0.
REQ-037 Two txdata writes with no frame between (0x11, 0x22) -> TOE=1; next frame sends 0x11.
REQ-038 SS_n raised after 4 bits -> RRDY stays 0, bit_count=0; next full frame 0x5A received intact.
REQ-039 eop-value=0x7E, control bit7 and bit9 set, receive 0x7E -> irq=1 one clk after RRDY; rxdata read -> EOP=1, irq stays 1.
REQ-040 No txdata primed, frame of 0xFF received -> MISO shifts 0x00; TOE unchanged.

Source files
------------

// File: rtl/q_sys_spi_slave.sv
// SPI mode-0 slave with a CPU register interface (rxdata/txdata/status/control/eop-value).
// Define SPI_SLAVE_MISO_TRISTATE_EN to float MISO while the slave is deselected.
module q_sys_spi_slave #(
  parameter int DATABITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  input  logic        read_n,
  input  logic        write_n,
  input  logic        spi_select,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata,
  output logic        endofpacket
);

  localparam int BCW = 5;
  localparam logic [BCW-1:0] BC_LAST = BCW'(DATABITS - 1);
  localparam logic [BCW-1:0] BC_FULL = BCW'(DATABITS);
  localparam logic [15:0] CTRL_MASK = 16'h03D8;

  typedef enum logic [2:0] {
    A_RXDATA = 3'd0,
    A_TXDATA = 3'd1,
    A_STATUS = 3'd2,
    A_CTRL   = 3'd3,
    A_EOPVAL = 3'd6
  } addr_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, ss_sync_q, ss_sync_d, mosi_sync_q, mosi_sync_d;
  logic sclk_prev_q, sclk_prev_d, ss_prev_q, ss_prev_d, acc_prev_q, acc_prev_d;
  logic [DATABITS-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [DATABITS-1:0] tx_hold_q, tx_hold_d, rx_hold_q, rx_hold_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [15:0] ctrl_q, ctrl_d, eop_val_q, eop_val_d, rdata_q, rdata_d;
  logic rrdy_q, rrdy_d, trdy_q, trdy_d, roe_q, roe_d, toe_q, toe_d, eop_q, eop_d, irq_q, irq_d;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic acc, acc_pulse, rd_en, wr_en, rx_done, rd_rx;
  logic [15:0] status;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;

  assign acc       = spi_select & (~read_n | ~write_n);
  assign acc_pulse = acc & ~acc_prev_q;
  assign rd_en     = acc_pulse & ~read_n;
  assign wr_en     = acc_pulse & ~write_n;
  assign rd_rx     = rd_en & (mem_addr == A_RXDATA);

  assign status = {6'b0, eop_q, toe_q | roe_q, rrdy_q, trdy_q, trdy_q & ss_s, toe_q, roe_q, 3'b0};

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;
    acc_prev_d  = acc;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    tx_hold_d   = tx_hold_q;
    rx_hold_d   = rx_hold_q;
    bit_cnt_d   = bit_cnt_q;
    ctrl_d      = ctrl_q;
    eop_val_d   = eop_val_q;
    rdata_d     = rdata_q;
    rrdy_d      = rrdy_q;
    trdy_d      = trdy_q;
    roe_d       = roe_q;
    toe_d       = toe_q;
    eop_d       = eop_q;
    rx_done     = 1'b0;

    // Frame sequencing: start and word-boundary reload both consume tx_holding only if primed.
    if (ss_fall) begin
      bit_cnt_d = '0;
      if (!trdy_q) begin
        tx_shift_d = tx_hold_q;
        trdy_d     = 1'b1;
      end else begin
        tx_shift_d = '0;
      end
    end else if (ss_rise) begin
      bit_cnt_d = '0;
    end else if (!ss_s) begin
      if (sclk_rise) begin
        rx_shift_d = {rx_shift_q[DATABITS-2:0], mosi_s};
        bit_cnt_d  = bit_cnt_q + 1'b1;
        rx_done    = (bit_cnt_q == BC_LAST);
      end else if (sclk_fall) begin
        if (bit_cnt_q == BC_FULL) begin
          bit_cnt_d = '0;
          if (!trdy_q) begin
            tx_shift_d = tx_hold_q;
            trdy_d     = 1'b1;
          end else begin
            tx_shift_d = '0;
          end
        end else begin
          tx_shift_d = tx_shift_q << 1;
        end
      end
    end

    if (wr_en) begin
      unique case (mem_addr)
        A_STATUS: begin
          eop_d = 1'b0;
          roe_d = 1'b0;
          toe_d = 1'b0;
        end
        A_CTRL:   ctrl_d    = data_from_cpu & CTRL_MASK;
        A_EOPVAL: eop_val_d = data_from_cpu;
        default: ;
      endcase
    end

    // Set events follow the status-write clear so they win on a collision.
    if (rd_rx && !rx_done) rrdy_d = 1'b0;
    if (rx_done) begin
      rx_hold_d = rx_shift_d;
      rrdy_d    = 1'b1;
      if (rrdy_q && !rd_rx) roe_d = 1'b1;
    end
    if (wr_en && mem_addr == A_TXDATA) begin
      if (trdy_q) begin
        tx_hold_d = data_from_cpu[DATABITS-1:0];
        trdy_d    = 1'b0;
      end else begin
        toe_d = 1'b1;
      end
      if (data_from_cpu == eop_val_q) eop_d = 1'b1;
    end
    if (rd_rx && (16'(rx_hold_q) == eop_val_q)) eop_d = 1'b1;

    if (rd_en) begin
      unique case (mem_addr)
        A_RXDATA: rdata_d = 16'(rx_hold_q);
        A_STATUS: rdata_d = status;
        A_CTRL:   rdata_d = ctrl_q;
        A_EOPVAL: rdata_d = eop_val_q;
        default:  rdata_d = '0;
      endcase
    end

    irq_d = |(status & ctrl_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      acc_prev_q  <= 1'b0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      tx_hold_q   <= '0;
      rx_hold_q   <= '0;
      bit_cnt_q   <= '0;
      ctrl_q      <= '0;
      eop_val_q   <= '0;
      rdata_q     <= '0;
      rrdy_q      <= 1'b0;
      trdy_q      <= 1'b1;
      roe_q       <= 1'b0;
      toe_q       <= 1'b0;
      eop_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      acc_prev_q  <= acc_prev_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      tx_hold_q   <= tx_hold_d;
      rx_hold_q   <= rx_hold_d;
      bit_cnt_q   <= bit_cnt_d;
      ctrl_q      <= ctrl_d;
      eop_val_q   <= eop_val_d;
      rdata_q     <= rdata_d;
      rrdy_q      <= rrdy_d;
      trdy_q      <= trdy_d;
      roe_q       <= roe_d;
      toe_q       <= toe_d;
      eop_q       <= eop_d;
      irq_q       <= irq_d;
    end
  end

  assign data_to_cpu   = rdata_q;
  assign irq           = irq_q;
  assign dataavailable = rrdy_q;
  assign readyfordata  = trdy_q;
  assign endofpacket   = eop_q;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign MISO = ss_s ? 1'bz : tx_shift_q[DATABITS-1];
`else
  assign MISO = ss_s ? 1'b0 : tx_shift_q[DATABITS-1];
`endif

endmodule
